// File: rtl/tx_frame_arbiter_if.sv
// rtl/tx_frame_arbiter_if.sv - request/stream/framer signal bundle for tx_frame_arbiter
interface tx_frame_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   src_axiiv;
    logic [2*NUM_REQ-1:0] src_axiid;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   gnt;
    logic                 axiov;
    logic [1:0]           axiod;
    logic                 frame_done;
    logic                 truncated;
    logic                 timeout;

    modport master (
        input  req, src_axiiv, src_axiid, tx_busy,
        output gnt, axiov, axiod, frame_done, truncated, timeout
    );

    modport slave (
        output req, src_axiiv, src_axiid, tx_busy,
        input  gnt, axiov, axiod, frame_done, truncated, timeout
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - round-robin arbiter sharing one RMII transmit framer
module tx_frame_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int MAX_DIBITS    = 56,
    parameter int IFG_CYCLES    = 48,
    parameter int START_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    tx_frame_arbiter_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [15:0] TO_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] MAX_D    = 16'(MAX_DIBITS);
    // The DRAIN exit clock already saw tx_busy low, so it is the first gap clock.
    localparam logic [15:0] GAP_LAST = 16'((IFG_CYCLES >= 2) ? IFG_CYCLES - 2 : 0);

    logic [2:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      g_idx;
    logic [PW-1:0]      pick_idx;
    logic               pick_ok;
    logic [15:0]        cnt;
    logic [NUM_REQ-1:0] gnt_r;
    logic               axiov_r;
    logic [1:0]         axiod_r;
    logic               frame_done_r;
    logic               truncated_r;
    logic               timeout_r;
    logic               g_valid;
    logic [1:0]         g_data;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan from the highest offset down so the nearest requester to ptr wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_add(ptr, k)]) begin
                pick_ok  = 1'b1;
                pick_idx = wrap_add(ptr, k);
            end
        end
    end

    assign g_valid = bus.src_axiiv[g_idx];
    assign g_data  = bus.src_axiid[{g_idx, 1'b0} +: 2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            g_idx        <= '0;
            cnt          <= '0;
            gnt_r        <= '0;
            axiov_r      <= 1'b0;
            axiod_r      <= 2'b00;
            frame_done_r <= 1'b0;
            truncated_r  <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            truncated_r  <= 1'b0;
            timeout_r    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        gnt_r <= NUM_REQ'(1) << pick_idx;
                        g_idx <= pick_idx;
                        ptr   <= wrap_add(pick_idx, 1);
                        cnt   <= '0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (g_valid) begin
                        axiov_r <= 1'b1;
                        axiod_r <= g_data;
                        cnt     <= 16'd1;
                        state   <= S_STREAM;
                    end else if (cnt == TO_LAST) begin
                        gnt_r     <= '0;
                        timeout_r <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STREAM: begin
                    if (!g_valid || cnt == MAX_D) begin
                        axiov_r     <= 1'b0;
                        axiod_r     <= 2'b00;
                        gnt_r       <= '0;
                        truncated_r <= g_valid;
                        cnt         <= '0;
                        state       <= S_DRAIN;
                    end else begin
                        axiod_r <= g_data;
                        cnt     <= cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == 16'd0) begin
                        cnt <= 16'd1;
                    end else if (!bus.tx_busy) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt >= GAP_LAST) begin
                        frame_done_r <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.axiov      = axiov_r;
    assign bus.axiod      = axiod_r;
    assign bus.frame_done = frame_done_r;
    assign bus.truncated  = truncated_r;
    assign bus.timeout    = timeout_r;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - randomized self-checking bench for tx_frame_arbiter
module tb_tx_frame_arbiter;
    localparam int N    = 2;
    localparam int MAXD = 56;
    localparam int IFG  = 48;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    tx_frame_arbiter_if #(.NUM_REQ(N)) bus ();

    tx_frame_arbiter #(
        .NUM_REQ(N), .MAX_DIBITS(MAXD), .IFG_CYCLES(IFG), .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int rr_ptr = 0;
    int exp_in[$];
    int got[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the rotating pointer.
    function automatic int pick(input int reqs);
        for (int k = 0; k < N; k++)
            if (reqs[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
        return -1;
    endfunction

    task automatic drive_sources(input int w, input bit v, input int d);
        for (int i = 0; i < N; i++) begin
            if (i == w) begin
                bus.src_axiiv[i]       = v;
                bus.src_axiid[2*i +: 2] = v ? 2'(d) : 2'($urandom);
            end else begin
                bus.src_axiiv[i]       = 1'($urandom);
                bus.src_axiid[2*i +: 2] = 2'($urandom);
            end
        end
    endtask

    task automatic grant_phase(input int reqs, output int w);
        int n;
        w = pick(reqs);
        bus.req = N'(reqs);
        n = 0;
        while (bus.gnt == 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("gnt_latency", n, 1);
        check("gnt_src", int'(bus.gnt), 1 << w);
        rr_ptr = (w + 1) % N;
        bus.req = N'(reqs) & ~(N'(1) << w);
    endtask

    task automatic stream_phase(input int w, input int delay, input int h);
        int len, nexp, drop_c, idx, n_done;
        int first_ov, last_ov, gnt_low, trunc_at, n_trunc, bad_od, bad_gnt, bad_to;
        len = exp_in.size();
        nexp = (len > MAXD) ? MAXD : len;
        drop_c = delay + len + h;
        got.delete();
        first_ov = -1; last_ov = -1; gnt_low = -1; trunc_at = -1;
        n_trunc = 0; bad_od = 0; bad_gnt = 0; bad_to = 0; n_done = -1;
        for (int c = 0; c < drop_c + IFG + 20; c++) begin
            if (c >= delay && c < delay + len) drive_sources(w, 1'b1, exp_in[c - delay]);
            else drive_sources(w, 1'b0, 0);
            bus.tx_busy = (c < drop_c);
            @(negedge clk);
            idx = c + 1;
            if (bus.axiov) begin
                got.push_back(int'(bus.axiod));
                if (first_ov < 0) first_ov = idx;
                last_ov = idx;
            end else if (bus.axiod != 2'b00) begin
                bad_od++;
            end
            if (bus.gnt == 0 && gnt_low < 0) gnt_low = idx;
            if (bus.gnt != 0 && (gnt_low >= 0 || int'(bus.gnt) != (1 << w))) bad_gnt++;
            if (bus.truncated) begin
                n_trunc++;
                trunc_at = idx;
            end
            if (bus.timeout) bad_to++;
            if (bus.frame_done) begin
                n_done = idx - drop_c;
                break;
            end
        end
        for (int i = 0; i < N; i++) bus.src_axiiv[i] = 1'b0;
        check("first_dibit_at", first_ov, delay + 1);
        check("dibit_count", got.size(), nexp);
        check("ov_contiguous", last_ov - first_ov + 1, nexp);
        for (int i = 0; i < nexp && i < got.size(); i++) check("dibit", got[i], exp_in[i] & 3);
        check("gnt_drop_with_ov", gnt_low, last_ov + 1);
        check("trunc_pulses", n_trunc, (len > MAXD) ? 1 : 0);
        check("trunc_at", trunc_at, (len > MAXD) ? last_ov + 1 : -1);
        check("od_zero_idle", bad_od, 0);
        check("gnt_hold", bad_gnt, 0);
        check("stray_timeout", bad_to, 0);
        check("frame_done_gap", n_done, IFG);
    endtask

    task automatic timeout_phase(input int w);
        int n, bad;
        n = 1;
        bad = 0;
        while (n < TMO + 10) begin
            drive_sources(w, 1'b0, 0);
            @(negedge clk);
            if (bus.axiov) bad++;
            if (bus.gnt == 0) break;
            n++;
        end
        for (int i = 0; i < N; i++) bus.src_axiiv[i] = 1'b0;
        check("timeout_cycles", n, TMO);
        check("timeout_pulse", int'(bus.timeout), 1);
        check("timeout_no_ov", bad, 0);
    endtask

    task automatic fill_random(input int len);
        exp_in.delete();
        for (int i = 0; i < len; i++) exp_in.push_back(int'($urandom_range(0, 3)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, seen;
        bus.req = '0;
        bus.src_axiiv = '0;
        bus.src_axiid = '0;
        bus.tx_busy = 1'b0;
        #1 rst = 1'b0;
        bus.req = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_axiov", int'(bus.axiov), 0);
        check("rst_axiod", int'(bus.axiod), 0);
        check("rst_pulses", int'({bus.frame_done, bus.truncated, bus.timeout}), 0);
        rst = 1'b1;
        grant_phase(3, w);

        exp_in.delete();
        for (int i = 0; i < 10; i++) exp_in.push_back(i % 4);
        stream_phase(w, 2, 70);

        for (int f = 0; f < 3; f++) begin
            grant_phase(3, w);
            fill_random(int'($urandom_range(5, 20)));
            stream_phase(w, int'($urandom_range(0, 5)), int'($urandom_range(2, 8)));
        end

        grant_phase(2, w);
        fill_random(80);
        stream_phase(w, 1, 4);
        grant_phase(3, w);
        fill_random(MAXD);
        stream_phase(w, 0, 3);
        grant_phase(3, w);
        fill_random(MAXD + 1);
        stream_phase(w, 0, 3);

        rr_ptr = 0;
        grant_phase(1, w);
        timeout_phase(w);
        grant_phase(3, w);
        timeout_phase(w);
        grant_phase(3, w);
        fill_random(12);
        stream_phase(w, 3, 5);

        // Asynchronous reset in the middle of a frame from source 0.
        grant_phase(1, w);
        fill_random(20);
        bus.tx_busy = 1'b1;
        seen = 0;
        for (int c = 0; c < 30 && seen < 5; c++) begin
            drive_sources(w, 1'b1, exp_in[c]);
            @(negedge clk);
            if (bus.axiov) seen++;
        end
        #3 rst = 1'b0;
        #1;
        check("async_rst_ov", int'(bus.axiov), 0);
        check("async_rst_gnt", int'(bus.gnt), 0);
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.src_axiiv[i] = 1'b0;
        bus.tx_busy = 1'b0;
        rst = 1'b1;
        rr_ptr = 0;
        grant_phase(3, w);
        fill_random(8);
        stream_phase(w, 0, 2);

        for (int f = 0; f < 25; f++) begin
            grant_phase(int'($urandom_range(1, (1 << N) - 1)), w);
            if ($urandom_range(0, 5) == 0) begin
                timeout_phase(w);
            end else begin
                fill_random(int'($urandom_range(1, 80)));
                stream_phase(w, int'($urandom_range(0, 30)), int'($urandom_range(2, 12)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single RMII transmit path (header-inserting framer, then PHY) between NUM_REQ payload sources.
- Round-robin grants one source at a time and forwards its dibit stream to the framer with one-cycle registered latency.
- Waits for the framer to finish the frame, then enforces the Ethernet inter-frame gap before the next grant.
- Guards the link against runaway frames (length cap) and stalled requesters (start timeout).

Parameters:
- NUM_REQ, 2, number of requesting sources (2..8).
- MAX_DIBITS, 56, maximum payload dibits forwarded per frame (fits the framer's 112-bit buffer).
- IFG_CYCLES, 48, idle clocks after framer goes quiet (96 bit times at 2 bits/clk, 50 MHz).
- START_TIMEOUT, 255, clocks a granted source may take to assert valid.

Ports:
- clk  in  1  50 MHz clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-source frame request, level; held until gnt seen
- src_axiiv  in  NUM_REQ  per-source dibit valid
- src_axiid  in  2*NUM_REQ  per-source dibit; source i on bits [2i+1:2i]
- tx_busy  in  1  framer output valid (its axiov); high while frame on wire
- gnt  out  NUM_REQ  one-hot grant; at most one bit high
- axiov  out  1  dibit valid to framer
- axiod  out  2  dibit to framer
- frame_done  out  1  one-cycle pulse when GAP completes
- truncated  out  1  one-cycle pulse when MAX_DIBITS cap hit
- timeout  out  1  one-cycle pulse when START_TIMEOUT expires

Behaviour:
- Reset (rst low, asynchronous): gnt=0, axiov=0, axiod=0, frame_done=0, truncated=0, timeout=0; state IDLE; dibit, gap and timeout counters 0; round-robin pointer 0 (source 0 highest priority). Releasing rst mid-frame leaves the framer to drain; the arbiter starts from IDLE.
- States: IDLE, GRANT, STREAM, DRAIN, GAP.
- IDLE: if any req, pick the first requesting index at or after the pointer (wrapping); gnt is registered next clock and state goes to GRANT. The pointer moves to granted index+1 mod NUM_REQ.
- GRANT: counter counts clocks. When src_axiiv[g] is high, register axiov=1 and axiod=src_axiid[g], set dibit count=1, go to STREAM. If the count reaches START_TIMEOUT first, gnt=0, pulse timeout, go to IDLE (no gap).
- STREAM: each clock with src_axiiv[g]=1 and count<MAX_DIBITS, forward the dibit (1-cycle latency) and increment count.
  - If src_axiiv[g]=0, axiov<=0, gnt<=0, go to DRAIN.
  - If src_axiiv[g]=1 and count==MAX_DIBITS, axiov<=0, gnt<=0, pulse truncated, go to DRAIN. Remaining source dibits are ignored.
  - A valid gap is end of frame; re-assertion is not rejoined.
- Non-granted src_axiiv/src_axiid are ignored at all times. req changes while granted have no effect.
- axiod is 0 whenever axiov is 0.
- DRAIN: wait a minimum of 2 clocks, then wait for tx_busy==0, then go to GAP with the gap counter cleared.
- GAP: count IFG_CYCLES clocks with axiov=0 and no grant. On the last one, pulse frame_done and go to IDLE. A req arriving during GAP is granted on the first IDLE clock.
- Simultaneous requests: round-robin only, no starvation. With all sources requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- Truncation and timeout both advance the pointer, same as a normal frame.

Test Plan:
- Reset defaults: hold rst low with req=2'b11 -> gnt=0, axiov=0. Release -> gnt=2'b01 one clock after IDLE is sampled.
- Single frame: source 0 streams 10 dibits 0,1,2,3,... -> axiov high exactly 10 clocks, each dibit one clock after input. tx_busy held high 70 clocks then low -> frame_done exactly 48 clocks after tx_busy falls.
- Round-robin: req=2'b11 held through three frames -> gnt sequence 01,10,01. No grant before frame_done of the prior frame.
- Truncation: source 1 valid for 80 dibits -> exactly 56 forwarded, truncated pulses once, gnt drops on the same clock as axiov.
- Timeout: source 0 granted, valid never asserted -> timeout pulse at clock 255, gnt=0, next grant goes to source 1 if it is requesting. No GAP is inserted.
- Async reset mid-STREAM: drop rst at dibit 5 -> axiov and gnt go 0 immediately without a clock edge. After release, state is IDLE and the pointer is 0.
